quad_step_decoder: RTL and testbench

//  Upstream stage for the 4-bit synchronous up/down counter. Decodes a quadrature

---
 rtl/quad_step_decoder.sv | 135 +++++++++++++
 tb/tb_quad_step_decoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: synchronises and debounces A/B, then decodes each
// legal Gray-code transition into a step pulse, direction level and wrapping position.
module quad_step_decoder #(
    parameter int FILTER_LEN = 4,
    parameter int POS_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    output logic             step,
    output logic             up_down,
    output logic             err,
    output logic [POS_W-1:0] position
);

    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t           state, state_nxt;
    logic             a_m, b_m, a_s, b_s;
    logic             a_f, b_f;
    logic [CNT_W-1:0] a_cnt, b_cnt;
    logic [1:0]       prev;
    logic [1:0]       settle;
    logic [1:0]       dph;
    logic             step_nxt, err_nxt, ud_nxt;
    logic [POS_W-1:0] pos_nxt;

    // Returns {next filtered value, next count}; the filtered value only follows
    // after FILTER_LEN consecutive disagreeing samples.
    function automatic logic [CNT_W:0] filt(input logic s, input logic f,
                                            input logic [CNT_W-1:0] cnt);
        if (s == f)
            return {f, {CNT_W{1'b0}}};
        if (cnt == CNT_LAST)
            return {s, {CNT_W{1'b0}}};
        return {f, cnt + 1'b1};
    endfunction

    // Quadrature phase index along the forward sequence 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] phase(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'd0;
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst)
            state <= INIT;
        else
            state <= state_nxt;
    end

    // INIT lingers until the cleared synchroniser has refilled, so the adopted
    // starting phase is the real input level and not the reset value.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (settle == 2'd2) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign dph = phase({a_f, b_f}) - phase(prev);

    always_comb begin
        step_nxt = 1'b0;
        err_nxt  = 1'b0;
        ud_nxt   = up_down;
        pos_nxt  = position;
        if (state == RUN) begin
            case (dph)
                2'd1: begin
                    step_nxt = 1'b1;
                    ud_nxt   = 1'b1;
                    pos_nxt  = position + POS_W'(1);
                end
                2'd3: begin
                    step_nxt = 1'b1;
                    ud_nxt   = 1'b0;
                    pos_nxt  = position - POS_W'(1);
                end
                2'd2:    err_nxt = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_m      <= 1'b0;
            b_m      <= 1'b0;
            a_s      <= 1'b0;
            b_s      <= 1'b0;
            a_f      <= 1'b0;
            b_f      <= 1'b0;
            a_cnt    <= '0;
            b_cnt    <= '0;
            prev     <= 2'b00;
            settle   <= 2'd0;
            step     <= 1'b0;
            err      <= 1'b0;
            up_down  <= 1'b1;
            position <= '0;
        end else begin
            a_m      <= a_in;
            b_m      <= b_in;
            a_s      <= a_m;
            b_s      <= b_m;
            step     <= step_nxt;
            err      <= err_nxt;
            up_down  <= ud_nxt;
            position <= pos_nxt;
            if (state == INIT) begin
                a_f    <= a_s;
                b_f    <= b_s;
                a_cnt  <= '0;
                b_cnt  <= '0;
                prev   <= {a_s, b_s};
                settle <= settle + 2'd1;
            end else begin
                {a_f, a_cnt} <= filt(a_s, a_f, a_cnt);
                {b_f, b_cnt} <= filt(b_s, b_f, b_cnt);
                prev         <= {a_f, b_f};
            end
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: expected step/err events are queued as
// inputs are driven and matched against every pulse the decoder emits.
module tb_quad_step_decoder;

    localparam int FL = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          a_in = 1'b0;
    logic          b_in = 1'b0;
    logic          step, up_down, err;
    logic [PW-1:0] position;

    always #5 clk = ~clk;

    quad_step_decoder #(.FILTER_LEN(FL), .POS_W(PW)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_in     (a_in),
        .b_in     (b_in),
        .step     (step),
        .up_down  (up_down),
        .err      (err),
        .position (position)
    );

    typedef struct packed {
        logic          e;
        logic          ud;
        logic [PW-1:0] pos;
    } ev_t;

    ev_t           sb[$];
    int            tests = 0;
    int            fails = 0;
    logic [PW-1:0] m_pos = '0;
    logic          m_ud  = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // kind: 0 = no event, 1 = forward step, 2 = reverse step, 3 = err
    task automatic push(input int kind);
        case (kind)
            1: begin m_pos = m_pos + 1'b1; m_ud = 1'b1; sb.push_back('{1'b0, 1'b1, m_pos}); end
            2: begin m_pos = m_pos - 1'b1; m_ud = 1'b0; sb.push_back('{1'b0, 1'b0, m_pos}); end
            3: sb.push_back('{1'b1, m_ud, m_pos});
            default: ;
        endcase
    endtask

    // Called at a falling edge; leaves the bench at a falling edge n cycles later.
    task automatic drive(input logic a, input logic b, input int kind, input int n);
        a_in = a;
        b_in = b;
        push(kind);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic a, input logic b);
        rst  = 1'b0;
        a_in = a;
        b_in = b;
        repeat (3) @(negedge clk);
        chk("rst_step", step, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_up_down", up_down, 1'b1);
        chk("rst_position", position, 0);
        rst   = 1'b1;
        m_pos = '0;
        m_ud  = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    always @(negedge clk) begin
        ev_t x;
        if (step === 1'b1 || err === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $error("FAIL unexpected_event: observed step=%0b err=%0b pos=%0d expected no event",
                       step, err, position);
            end else begin
                x = sb.pop_front();
                assert ({err, step, up_down, position} === {x.e, ~x.e, x.ud, x.pos})
                else begin
                    fails++;
                    $error("FAIL event: observed err=%0b step=%0b ud=%0b pos=%0d expected err=%0b step=%0b ud=%0b pos=%0d",
                           err, step, up_down, position, x.e, ~x.e, x.ud, x.pos);
                end
            end
        end
    end

    initial begin
        int lat;
        @(negedge clk);

        // 1: reset with 11 held; INIT adopts 11 silently
        do_reset(1'b1, 1'b1);
        repeat (20) @(negedge clk);
        chk("t1_position", position, 0);
        chk("t1_up_down", up_down, 1'b1);

        // 2: forward sequence with first-step latency measurement
        do_reset(1'b0, 1'b0);
        a_in = 1'b1;
        push(1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (step === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk("t2_latency", lat, FL + 3);
        repeat (6) @(negedge clk);
        drive(1'b1, 1'b1, 1, 10);
        drive(1'b0, 1'b1, 1, 10);
        drive(1'b0, 1'b0, 1, 10);
        chk("t2_position", position, 4);
        chk("t2_up_down", up_down, 1'b1);

        // 3: reverse sequence from zero wraps downward
        do_reset(1'b0, 1'b0);
        drive(1'b0, 1'b1, 2, 10);
        drive(1'b1, 1'b1, 2, 10);
        drive(1'b1, 1'b0, 2, 10);
        drive(1'b0, 1'b0, 2, 10);
        chk("t3_position", position, 252);
        chk("t3_up_down", up_down, 1'b0);

        // 4: 3-cycle glitch is swallowed; 4-cycle pulse gives fwd then rev
        drive(1'b1, 1'b0, 0, FL - 1);
        drive(1'b0, 1'b0, 0, 15);
        chk("t4_glitch_position", position, 252);
        drive(1'b1, 1'b0, 1, FL);
        drive(1'b0, 1'b0, 2, 15);
        chk("t4_pulse_position", position, 252);

        // 5: simultaneous A/B change flags err, then a legal forward step
        drive(1'b1, 1'b1, 3, 10);
        chk("t5_err_position", position, 252);
        drive(1'b0, 1'b1, 1, 10);
        chk("t5_up_down", up_down, 1'b1);

        // 6: ten forward steps, then reset while a filter count is in flight
        drive(1'b0, 1'b0, 1, 10);
        drive(1'b1, 1'b0, 1, 10);
        drive(1'b1, 1'b1, 1, 10);
        drive(1'b0, 1'b1, 1, 10);
        drive(1'b0, 1'b0, 1, 10);
        drive(1'b1, 1'b0, 1, 10);
        drive(1'b1, 1'b1, 1, 10);
        drive(1'b0, 1'b1, 1, 10);
        drive(1'b0, 1'b0, 1, 10);
        drive(1'b1, 1'b0, 1, 10);
        chk("t6_pre_position", position, 7);
        drive(1'b1, 1'b1, 0, 4);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_rst_position", position, 0);
        rst   = 1'b1;
        m_pos = '0;
        m_ud  = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_position", position, 0);
        chk("t6_up_down", up_down, 1'b1);
        drive(1'b0, 1'b1, 1, 10);
        chk("t6_after_position", position, 1);

        repeat (10) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
